fetch_queue: RTL

Instruction-fetch front end that consumes the dual fetch addresses (`pc_f1`/`pc_f2`) produced by the next-PC logic. It issues paired read requests to instruction memory and returns the hold/enable signal that freezes the PC. In-order responses are collected into a small ring buffer, and instruction pairs with their PCs are presented to decode under a valid/ready handshake. A branch/jump redirect flushes the buffer, and responses still in flight are discarded.

---
 rtl/fetch_queue.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: dual-instruction fetch front end.
// Issues paired fetch requests, collects in-order responses into a ring
// buffer and hands instruction pairs to decode. A redirect (flush) empties
// the buffer and arranges for still-in-flight responses to be discarded.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                pc_f1,
    input  logic [31:0]                pc_f2,
    output logic                       pc_hold,
    input  logic                       flush,
    output logic                       imem_req_valid,
    output logic [31:0]                imem_req_addr1,
    output logic [31:0]                imem_req_addr2,
    input  logic                       imem_req_ready,
    input  logic                       imem_rsp_valid,
    input  logic [31:0]                imem_rsp_inst1,
    input  logic [31:0]                imem_rsp_inst2,
    output logic                       dec_valid,
    output logic [31:0]                dec_pc1,
    output logic [31:0]                dec_pc2,
    output logic [31:0]                dec_inst1,
    output logic [31:0]                dec_inst2,
    input  logic                       dec_ready,
    output logic [$clog2(DEPTH):0]     occupancy
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] alloc_q, alloc_d;
    logic [PW-1:0] fill_q,  fill_d;
    logic [PW-1:0] rd_q,    rd_d;
    logic [PW-1:0] drop_q,  drop_d;

    logic [31:0] pc1_mem   [DEPTH];
    logic [31:0] pc2_mem   [DEPTH];
    logic [31:0] inst1_mem [DEPTH];
    logic [31:0] inst2_mem [DEPTH];

    logic [PW-1:0] outstanding;
    logic [PW-1:0] filled;
    logic [PW-1:0] drop_sum;
    logic          full;
    logic          req_fire;
    logic          rsp_fill;
    logic          pop;

    assign occupancy   = alloc_q - rd_q;
    assign outstanding = alloc_q - fill_q;
    assign filled      = fill_q - rd_q;
    // Bounded by DEPTH: no new request is issued while drops are pending.
    assign drop_sum    = drop_q + outstanding;
    assign full        = (alloc_q[IW-1:0] == rd_q[IW-1:0]) && (alloc_q[IW] != rd_q[IW]);

    assign imem_req_valid = !rst && !flush && (drop_q == '0) && !full;
    assign imem_req_addr1 = pc_f1;
    assign imem_req_addr2 = pc_f2;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign pc_hold        = rst ? 1'b1 : (flush ? 1'b0 : !req_fire);

    // A response with nothing outstanding and nothing to drop is spurious.
    assign rsp_fill = imem_rsp_valid && (drop_q == '0) && (outstanding != '0);

    assign dec_valid = !rst && !flush && (filled != '0);
    assign dec_pc1   = pc1_mem[rd_q[IW-1:0]];
    assign dec_pc2   = pc2_mem[rd_q[IW-1:0]];
    assign dec_inst1 = inst1_mem[rd_q[IW-1:0]];
    assign dec_inst2 = inst2_mem[rd_q[IW-1:0]];
    assign pop       = dec_valid && dec_ready;

    // Pointer and drop-count next state; flush overrides push, fill and pop.
    always_comb begin
        alloc_d = alloc_q;
        fill_d  = fill_q;
        rd_d    = rd_q;
        drop_d  = drop_q;
        if (flush) begin
            fill_d = alloc_q;
            rd_d   = alloc_q;
            // A response landing in the flush cycle counts as one dropped.
            if (imem_rsp_valid && (drop_sum != '0))
                drop_d = drop_sum - PW'(1);
            else
                drop_d = drop_sum;
        end else begin
            if (req_fire)
                alloc_d = alloc_q + PW'(1);
            if (rsp_fill)
                fill_d = fill_q + PW'(1);
            if (imem_rsp_valid && (drop_q != '0))
                drop_d = drop_q - PW'(1);
            if (pop)
                rd_d = rd_q + PW'(1);
        end
    end

    // Pointer and drop-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_q <= '0;
            fill_q  <= '0;
            rd_q    <= '0;
            drop_q  <= '0;
        end else begin
            alloc_q <= alloc_d;
            fill_q  <= fill_d;
            rd_q    <= rd_d;
            drop_q  <= drop_d;
        end
    end

    // Entry storage: PCs written on request fire, instructions on fill.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pc1_mem[alloc_q[IW-1:0]] <= pc_f1;
            pc2_mem[alloc_q[IW-1:0]] <= pc_f2;
        end
        if (rsp_fill && !flush && !rst) begin
            inst1_mem[fill_q[IW-1:0]] <= imem_rsp_inst1;
            inst2_mem[fill_q[IW-1:0]] <= imem_rsp_inst2;
        end
    end
endmodule
